uart_frame_parser: RTL and testbench

Framing stage that sits directly downstream of the UART receiver. It consumes the receiver's AXI-Stream byte output and hunts for a sync byte. It then collects address, length, payload and an XOR checksum, buffering the payload internally. Only frames with a valid checksum are replayed as an AXI-Stream packet, with the address on tuser and tlast on the final byte; malformed or stalled frames are dropped and flagged.

---
 rtl/uart_frame_parser.sv | 202 ++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
// Sits behind the UART receiver. It hunts for the sync byte, then collects
// address, length, payload and an XOR checksum, buffering the payload. A frame
// whose checksum matches is replayed as an AXI-Stream packet with the address
// on tuser and tlast on the final byte. Malformed or stalled frames are dropped
// and flagged with one-cycle status pulses.
module uart_frame_parser #(
  parameter int         MAX_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_axis_tdata,
  input  logic       input_axis_tvalid,
  output logic       input_axis_tready,
  output logic [7:0] output_axis_tdata,
  output logic       output_axis_tvalid,
  input  logic       output_axis_tready,
  output logic       output_axis_tlast,
  output logic [7:0] output_axis_tuser,
  output logic       busy,
  output logic       frame_ok,
  output logic       checksum_error,
  output logic       length_error,
  output logic       timeout_error
);

  localparam int          IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [31:0] TO_LAST   = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_SEND
  } state_t;

  state_t      state;
  logic [7:0]  addr;
  logic [7:0]  len;
  logic [7:0]  chk;
  logic [7:0]  cnt;
  logic [7:0]  rd;
  logic [7:0]  rd_next;
  logic [31:0] tcnt;
  logic [7:0]  pbuf [MAX_LEN];

  logic in_fire;
  logic out_fire;
  logic timer_on;
  logic timer_hit;

  // A length of zero or beyond the buffer depth cannot be framed.
  function automatic logic len_bad(input logic [7:0] b);
    return (b == 8'd0) || (b > MAX_LEN_B);
  endfunction

  assign in_fire  = input_axis_tvalid & input_axis_tready;
  assign out_fire = output_axis_tvalid & output_axis_tready;
  assign rd_next  = rd + 8'd1;
  assign busy     = (state != S_IDLE);

  // The inter-byte timer only matters while a frame is being received; an
  // accepted byte on the limit cycle takes priority over the timeout.
  assign timer_on  = (state == S_ADDR) || (state == S_LEN) ||
                     (state == S_DATA) || (state == S_CHK);
  assign timer_hit = (TIMEOUT != 0) && timer_on && !in_fire && (tcnt == TO_LAST);

  // Frame datapath: header fields, running checksum and payload buffer.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      case (state)
        S_ADDR: begin
          addr <= input_axis_tdata;
          chk  <= input_axis_tdata;
        end
        S_LEN: begin
          if (!len_bad(input_axis_tdata)) begin
            len <= input_axis_tdata;
            chk <= chk ^ input_axis_tdata;
          end
        end
        S_DATA: begin
          pbuf[cnt[IDX_W-1:0]] <= input_axis_tdata;
          chk                  <= chk ^ input_axis_tdata;
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered stream outputs, status pulses and timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      cnt                <= 8'd0;
      rd                 <= 8'd0;
      tcnt               <= 32'd0;
      input_axis_tready  <= 1'b0;
      output_axis_tdata  <= 8'd0;
      output_axis_tvalid <= 1'b0;
      output_axis_tlast  <= 1'b0;
      output_axis_tuser  <= 8'd0;
      frame_ok           <= 1'b0;
      checksum_error     <= 1'b0;
      length_error       <= 1'b0;
      timeout_error      <= 1'b0;
    end else begin
      frame_ok       <= 1'b0;
      checksum_error <= 1'b0;
      length_error   <= 1'b0;
      timeout_error  <= 1'b0;

      // Input is open in every state except while replaying a packet.
      if (state != S_SEND) begin
        input_axis_tready <= 1'b1;
      end

      if (!timer_on || in_fire || timer_hit) begin
        tcnt <= 32'd0;
      end else if (TIMEOUT != 0) begin
        tcnt <= tcnt + 32'd1;
      end

      case (state)
        S_IDLE: begin
          if (in_fire && (input_axis_tdata == SYNC_BYTE)) begin
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (in_fire) begin
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (in_fire) begin
            if (len_bad(input_axis_tdata)) begin
              length_error <= 1'b1;
              state        <= S_IDLE;
            end else begin
              cnt   <= 8'd0;
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (in_fire) begin
            cnt <= cnt + 8'd1;
            if (cnt == len - 8'd1) begin
              state <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (in_fire) begin
            if (input_axis_tdata == chk) begin
              frame_ok           <= 1'b1;
              rd                 <= 8'd0;
              state              <= S_SEND;
              input_axis_tready  <= 1'b0;
              output_axis_tvalid <= 1'b1;
              output_axis_tdata  <= pbuf[0];
              output_axis_tuser  <= addr;
              output_axis_tlast  <= (len == 8'd1);
            end else begin
              checksum_error <= 1'b1;
              state          <= S_IDLE;
            end
          end
        end
        S_SEND: begin
          if (out_fire) begin
            if (output_axis_tlast) begin
              state              <= S_IDLE;
              input_axis_tready  <= 1'b1;
              output_axis_tvalid <= 1'b0;
              output_axis_tdata  <= 8'd0;
              output_axis_tuser  <= 8'd0;
              output_axis_tlast  <= 1'b0;
            end else begin
              rd                <= rd_next;
              output_axis_tdata <= pbuf[rd_next[IDX_W-1:0]];
              output_axis_tlast <= (rd_next == len - 8'd1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      if (timer_hit) begin
        timeout_error <= 1'b1;
        state         <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: framing, checksum and length errors,
// inter-byte timeout, stalled output and reset mid-frame.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TO      = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] input_axis_tdata = 8'd0;
  logic       input_axis_tvalid = 1'b0;
  logic       output_axis_tready = 1'b1;

  logic       input_axis_tready;
  logic [7:0] output_axis_tdata;
  logic       output_axis_tvalid;
  logic       output_axis_tlast;
  logic [7:0] output_axis_tuser;
  logic       busy, frame_ok, checksum_error, length_error, timeout_error;

  logic       in_rdy1;
  logic [7:0] out_data1, out_user1;
  logic       out_vld1, out_last1;
  logic       busy1, ok1, cerr1, lerr1, terr1;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .input_axis_tdata(input_axis_tdata), .input_axis_tvalid(input_axis_tvalid),
    .input_axis_tready(input_axis_tready),
    .output_axis_tdata(output_axis_tdata), .output_axis_tvalid(output_axis_tvalid),
    .output_axis_tready(output_axis_tready), .output_axis_tlast(output_axis_tlast),
    .output_axis_tuser(output_axis_tuser),
    .busy(busy), .frame_ok(frame_ok), .checksum_error(checksum_error),
    .length_error(length_error), .timeout_error(timeout_error)
  );

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT(0)) dut_noto (
    .clk(clk), .rst(rst),
    .input_axis_tdata(input_axis_tdata), .input_axis_tvalid(input_axis_tvalid),
    .input_axis_tready(in_rdy1),
    .output_axis_tdata(out_data1), .output_axis_tvalid(out_vld1),
    .output_axis_tready(output_axis_tready), .output_axis_tlast(out_last1),
    .output_axis_tuser(out_user1),
    .busy(busy1), .frame_ok(ok1), .checksum_error(cerr1),
    .length_error(lerr1), .timeout_error(terr1)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [7:0] u;
    logic       l;
    int         c;
  } beat_t;

  beat_t got[$];
  beat_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_ok = 0, n_cerr = 0, n_lerr = 0, n_terr = 0, n_terr1 = 0;
  bit mon_en = 1'b0;
  bit rand_rdy = 1'b0;
  logic        held_vld = 1'b0;
  logic [16:0] held = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: capture beats, count pulses, check AXI-Stream hold rules.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (held_vld) begin
        check("hold_vld", {31'd0, output_axis_tvalid}, 32'd1);
        check("hold_beat", {15'd0, output_axis_tdata, output_axis_tuser, output_axis_tlast},
              {15'd0, held});
      end
      held_vld = output_axis_tvalid && !output_axis_tready;
      held     = {output_axis_tdata, output_axis_tuser, output_axis_tlast};
      if (output_axis_tvalid) begin
        check("in_rdy_in_send", {31'd0, input_axis_tready}, 32'd0);
        if (output_axis_tready)
          got.push_back('{d: output_axis_tdata, u: output_axis_tuser, l: output_axis_tlast, c: cyc});
      end else begin
        check("idle_out_zero", {15'd0, output_axis_tdata, output_axis_tuser, output_axis_tlast}, 32'd0);
      end
      if (frame_ok)       n_ok++;
      if (checksum_error) n_cerr++;
      if (length_error)   n_lerr++;
      if (timeout_error)  n_terr++;
      if (terr1)          n_terr1++;
    end else begin
      held_vld = 1'b0;
    end
  end

  // Downstream ready: held high unless the random-stall phase is active.
  initial forever begin
    @(posedge clk);
    #1;
    output_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Present one byte after an idle gap; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap = 0);
    int n;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    input_axis_tdata  = b;
    input_axis_tvalid = 1'b1;
    n = 0;
    while (!input_axis_tready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) check("in_ready_wait", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    input_axis_tvalid = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [7:0] u, input logic l);
    exp_q.push_back('{d: d, u: u, l: l, c: 0});
  endtask

  task automatic check_frame(input bit consec);
    int n;
    int m;
    n = 0;
    while (got.size() < exp_q.size() && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat_count", got.size(), exp_q.size());
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check("beat_data", {24'd0, got[i].d}, {24'd0, exp_q[i].d});
      check("beat_user", {24'd0, got[i].u}, {24'd0, exp_q[i].u});
      check("beat_last", {31'd0, got[i].l}, {31'd0, exp_q[i].l});
      if (consec) check("beat_cycle", got[i].c - got[0].c, i);
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int ok0, le0, ce0, te0;
    logic [7:0] c;
    logic [7:0] b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", {31'd0, input_axis_tready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_vld", {31'd0, output_axis_tvalid}, 32'd0);
    check("rst_pulses", {28'd0, frame_ok, checksum_error, length_error, timeout_error}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_after_rst", {31'd0, input_axis_tready}, 32'd1);

    // Good frame, three payload bytes
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h13);
    check("t1_frame_ok", {31'd0, frame_ok}, 32'd1);
    check("t1_first_vld", {31'd0, output_axis_tvalid}, 32'd1);
    check("t1_first_data", {24'd0, output_axis_tdata}, 32'h11);
    check("t1_tuser", {24'd0, output_axis_tuser}, 32'h10);
    check("t1_in_rdy_low", {31'd0, input_axis_tready}, 32'd0);
    push_exp(8'h11, 8'h10, 1'b0);
    push_exp(8'h22, 8'h10, 1'b0);
    push_exp(8'h33, 8'h10, 1'b1);
    @(posedge clk);
    #1;
    check("t1_ok_one_cycle", {31'd0, frame_ok}, 32'd0);
    check_frame(1'b1);
    check("t1_busy_done", {31'd0, busy}, 32'd0);
    check("t1_in_rdy_back", {31'd0, input_axis_tready}, 32'd1);

    // Bad checksum, then a good frame
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h14);
    check("t2_cerr", {31'd0, checksum_error}, 32'd1);
    check("t2_no_ok", {31'd0, frame_ok}, 32'd0);
    check("t2_no_vld", {31'd0, output_axis_tvalid}, 32'd0);
    check("t2_idle", {31'd0, busy}, 32'd0);
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h01);
    send_byte(8'h5A); send_byte(8'h5C);
    check("t2_next_ok", {31'd0, frame_ok}, 32'd1);
    push_exp(8'h5A, 8'h07, 1'b1);
    check_frame(1'b1);

    // Junk before sync, zero length, oversize length
    send_byte(8'h00); send_byte(8'hFF);
    check("t3_junk_idle", {31'd0, busy}, 32'd0);
    send_byte(8'hA5);
    check("t3_sync_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h20); send_byte(8'h00);
    check("t3_len0_err", {31'd0, length_error}, 32'd1);
    check("t3_len0_idle", {31'd0, busy}, 32'd0);
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'(MAX_LEN + 1));
    check("t3_lenbig_err", {31'd0, length_error}, 32'd1);
    check("t3_lenbig_idle", {31'd0, busy}, 32'd0);

    // Bytes arriving exactly on the timeout limit are still accepted
    te0 = n_terr;
    send_byte(8'hA5);
    send_byte(8'h30, TO - 1); send_byte(8'h01, TO - 1);
    send_byte(8'h44, TO - 1); send_byte(8'h75, TO - 1);
    check("t4_edge_ok", {31'd0, frame_ok}, 32'd1);
    push_exp(8'h44, 8'h30, 1'b1);
    check_frame(1'b1);
    check("t4_edge_no_to", n_terr - te0, 0);

    // Full-length frame with downstream stalls
    rand_rdy = 1'b1;
    c = 8'h5E ^ 8'(MAX_LEN);
    send_byte(8'hA5); send_byte(8'h5E); send_byte(8'(MAX_LEN));
    for (int i = 0; i < MAX_LEN; i++) begin
      b = 8'(i * 19 + 7);
      c = c ^ b;
      send_byte(b);
      push_exp(b, 8'h5E, (i == MAX_LEN - 1));
    end
    send_byte(c);
    check("t5_ok", {31'd0, frame_ok}, 32'd1);
    check_frame(1'b0);
    rand_rdy = 1'b0;
    check("t5_in_rdy_back", {31'd0, input_axis_tready}, 32'd1);

    // Reset in the middle of DATA
    ok0 = n_ok; ce0 = n_cerr; le0 = n_lerr; te0 = n_terr;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    #1;
    check("t6_rst_rdy", {31'd0, input_axis_tready}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rdy_back", {31'd0, input_axis_tready}, 32'd1);
    send_byte(8'hA5); send_byte(8'h44); send_byte(8'h02);
    send_byte(8'h0F); send_byte(8'hF0); send_byte(8'hB9);
    push_exp(8'h0F, 8'h44, 1'b0);
    push_exp(8'hF0, 8'h44, 1'b1);
    check_frame(1'b1);
    check("t6_ok_count", n_ok - ok0, 1);
    check("t6_no_err", (n_cerr - ce0) + (n_lerr - le0) + (n_terr - te0), 0);

    // Timeout in DATA; disabled-timeout instance waits forever
    te0 = n_terr;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'hAA);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("t7_not_yet", {31'd0, timeout_error}, 32'd0);
    check("t7_still_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("t7_timeout", {31'd0, timeout_error}, 32'd1);
    check("t7_idle", {31'd0, busy}, 32'd0);
    repeat (3 * TO) @(posedge clk);
    #1;
    check("t7_once", n_terr - te0, 1);
    check("t7_noto_busy", {31'd0, busy1}, 32'd1);
    check("t7_noto_no_err", n_terr1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
